// File: rtl/eprisc_serial_receiver.sv
// TTL serial receiver for the epRISC I/O controller: mid-bit sampling, parity and
// framing checks, and a show-ahead receive FIFO with RTS flow control.
module eprisc_serial_receiver #(
  parameter int DIVISOR    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 2
) (
  input  logic                          iBoardClock,
  input  logic                          iBoardReset,
  input  logic                          iSerialRX,
  input  logic                          iReadStrobe,
  input  logic                          iClearErrors,
  output logic [DATA_BITS-1:0]          oData,
  output logic                          oValid,
  output logic [$clog2(FIFO_DEPTH):0]   oCount,
  output logic                          oFull,
  output logic                          oRTS,
  output logic                          oFrameError,
  output logic                          oParityError,
  output logic                          oOverrun,
  output logic [2:0]                    oState
);

  localparam int TW = $clog2(DIVISOR);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = 4;

  localparam logic [TW-1:0] SAMPLE_T  = TW'(DIVISOR / 2 - 1);
  localparam logic [TW-1:0] END_T     = TW'(DIVISOR - 1);
  localparam logic [BW-1:0] DATA_N    = BW'(DATA_BITS);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MARGIN_C  = CW'(RTS_MARGIN);
  localparam logic          ODD_P     = (PARITY == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 sync1, rxs, rxs_d;
  logic [2:0]           state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_pend, frame_pend;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        count, count_next;
  logic                 valid, full, rts;

  logic sample, end_bit, last_stop, frame_bad, good;
  logic push, pop, frame_set, parity_set, overrun_set;

  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= iSerialRX;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign sample    = (state != S_IDLE) && (tick == SAMPLE_T);
  assign end_bit   = (tick == END_T);
  assign last_stop = (state == S_STOP) && sample && (bit_cnt == STOP_LAST);
  assign frame_bad = frame_pend | ~rxs;
  assign good      = last_stop && !frame_bad;

  // Handshake: oValid is the "valid" of the head entry; iReadStrobe acts as
  // "ready" and a pop happens only on a cycle where both are high.
  assign pop         = iReadStrobe && valid;
  assign push        = good && (!full || pop);
  assign overrun_set = good && full && !pop;
  assign parity_set  = good && par_pend;
  assign frame_set   = last_stop && frame_bad;
  assign count_next  = count + CW'(push) - CW'(pop);

  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) begin
      state      <= S_IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_pend   <= 1'b0;
      frame_pend <= 1'b0;
    end else begin
      if (state != S_IDLE) tick <= end_bit ? '0 : tick + TW'(1);
      case (state)
        S_IDLE: begin
          if (rxs_d && !rxs) begin
            state      <= S_START;
            tick       <= '0;
            par_pend   <= 1'b0;
            frame_pend <= 1'b0;
          end
        end
        S_START: begin
          if (sample && rxs) begin
            state <= S_IDLE;
          end else if (end_bit) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (sample) begin
            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + BW'(1);
          end
          if (end_bit && bit_cnt == DATA_N) begin
            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            bit_cnt <= '0;
          end
        end
        S_PARITY: begin
          if (sample) par_pend <= ((^shift_reg) ^ rxs) != ODD_P;
          if (end_bit) begin
            state   <= S_STOP;
            bit_cnt <= '0;
          end
        end
        S_STOP: begin
          // Leave at the last stop sample so a back-to-back start edge is not missed.
          if (sample) begin
            if (!rxs) frame_pend <= 1'b1;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == STOP_LAST) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iBoardClock) begin
    if (push) mem[wptr] <= shift_reg;
  end

  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      valid <= 1'b0;
      full  <= 1'b0;
      rts   <= 1'b1;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count_next;
      valid <= (count_next != '0);
      full  <= (count_next == DEPTH_C);
      rts   <= (DEPTH_C - count_next) > MARGIN_C;
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge iBoardClock or posedge iBoardReset) begin
    if (iBoardReset) begin
      oFrameError  <= 1'b0;
      oParityError <= 1'b0;
      oOverrun     <= 1'b0;
    end else begin
      if (frame_set)         oFrameError <= 1'b1;
      else if (iClearErrors) oFrameError <= 1'b0;
      if (parity_set)        oParityError <= 1'b1;
      else if (iClearErrors) oParityError <= 1'b0;
      if (overrun_set)       oOverrun <= 1'b1;
      else if (iClearErrors) oOverrun <= 1'b0;
    end
  end

  assign oData  = valid ? mem[rptr] : '0;
  assign oValid = valid;
  assign oCount = count;
  assign oFull  = full;
  assign oRTS   = rts;
  assign oState = state;

endmodule

// File: doc/eprisc_serial_receiver.md
Name: eprisc_serial_receiver

Overview:
Parametrised TTL serial receiver with a receive FIFO, for the epRISC I/O controller's iTTLSerialRX pin. It supersedes the fixed-format receive path. Frame format, bit timing and buffer depth are set at elaboration. It adds mid-bit sampling with false-start rejection, parity and framing checks, overrun tracking and RTS flow control. The CPU side sees a show-ahead FIFO with a read strobe.

Parameters:
DIVISOR, 16, board clocks per serial bit; minimum 4, even.
DATA_BITS, 8, data bits per frame; range 5..9, sent LSB first.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
STOP_BITS, 1, stop bits checked; 1 or 2.
FIFO_DEPTH, 16, receive FIFO entries; power of 2, minimum 4.
RTS_MARGIN, 2, oRTS is deasserted when free entries are at or below this value.

Ports:
iBoardClock  in  1  system clock; all logic is on its rising edge.
iBoardReset  in  1  asynchronous reset, active-high.
iSerialRX  in  1  asynchronous serial line; idles high.
iReadStrobe  in  1  pops the head entry when oValid=1.
iClearErrors  in  1  clears the sticky error flags.
oData  out  DATA_BITS  head-of-FIFO data (show-ahead).
oValid  out  1  FIFO not empty.
oCount  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
oFull  out  1  occupancy equals FIFO_DEPTH.
oRTS  out  1  1 means ready to receive.
oFrameError  out  1  sticky; a stop bit was sampled low.
oParityError  out  1  sticky; parity mismatch.
oOverrun  out  1  sticky; a good frame was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-high) clears everything:
  - FSM goes to IDLE; FIFO is empty.
  - oData=0, oValid=0, oCount=0, oFull=0, oRTS=1, all error flags=0.
  - Synchroniser flops are set to 1 (line idle).
  - Reset mid-frame discards the partial frame; the next falling edge after release is treated as a new start.
- Synchroniser: two flops on iSerialRX. All FSM decisions use the second flop's output (rxs), so the line-to-decision latency is 2 clocks.
- Bit counter: tick counter runs 0..DIVISOR-1. The sample point is tick DIVISOR/2-1 of each bit.
- FSM states:
  - IDLE: a 1->0 transition of rxs moves to START and zeroes the tick counter.
  - START: at the sample point, rxs=1 is a false start and returns to IDLE with no flags set. rxs=0 moves to DATA at the end of the bit period.
  - DATA: rxs is sampled into a shift register, LSB first, DATA_BITS times. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample one bit. Even mode expects the XOR of data and parity bit to be 0; odd mode expects 1. A mismatch sets a pending parity flag.
  - STOP: sample STOP_BITS bits. Any low sample sets a pending frame flag.
  - Leaving STOP: after the last stop sample the FSM returns to IDLE at that same sample point, not at the end of the bit. This allows resync with back-to-back frames.
- Commit, on the cycle the FSM leaves STOP:
  - Frame error: oFrameError=1; data is discarded.
  - Otherwise: a pending parity error sets oParityError=1, but the data is still pushed.
  - FIFO full and frame otherwise good: oOverrun=1; data is dropped; FIFO contents are unchanged.
- FIFO:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth.
  - A push appears on oData/oValid on the next clock.
  - iReadStrobe with oValid=0 is ignored and causes no pointer underflow.
  - Push and pop in the same cycle: occupancy is unchanged; this is legal when full (the pop frees the slot, so there is no overrun) and when holding 1 entry.
  - oFull and oCount are registered and consistent with oValid every cycle.
- oRTS = (FIFO_DEPTH - oCount) > RTS_MARGIN, registered.
- iClearErrors clears all three sticky flags on the next clock. If a set event occurs in the same cycle, the set wins.
- Output width rule: oData carries exactly DATA_BITS bits; there is no padding.

Test Plan:
- Defaults; send 0x55, 8N1, 16 clocks/bit, then hold idle -> oValid=1 and oData=0x55 within 2 clocks of the stop sample; oCount=1; all flags 0.
- 3-clock low glitch on iSerialRX -> no push; FSM returns to IDLE; flags 0; a following 0xA3 frame is received correctly.
- PARITY=1: send 0x07 with parity bit 0 -> oData=0x07 and oParityError=1. Pulse iClearErrors -> flag 0 the next clock.
- Send 0x3C with the stop bit forced low -> oFrameError=1; oCount unchanged; no push.
- FIFO_DEPTH=4, RTS_MARGIN=2, 5 back-to-back frames 0x01..0x05, no reads:
  - oRTS drops after the 2nd frame.
  - oFull=1 after the 4th.
  - The 5th frame sets oOverrun; reads return 0x01..0x04 in order.
- FIFO full; assert iReadStrobe on the commit cycle of a new frame 0x99 -> no overrun; oCount stays 4; 0x99 is read last.
- Assert iBoardReset mid-DATA of frame 0xF0 -> all outputs at reset values immediately; the next frame 0x12 is received correctly.
